// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, FSM states and a conditional two's-complement helper.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Widest value the helper handles; covers a 2*64-bit product.
    localparam int MAX_W = 128;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    // Returns -x when neg is set, else x. Callers zero-extend
    // into MAX_W and truncate the result back to their width.
    function automatic logic [MAX_W-1:0] cond_neg(
        input logic [MAX_W-1:0] x,
        input logic             neg
    );
        return neg ? -x : x;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit producing hi/lo.
// Ports: clock, reset(async low), start/op/a/b request, flush abort,
//        busy/done handshake, hi/lo result, div_by_zero flag.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    state_t state;
    state_t nxt;

    logic [CNT_W-1:0] cnt;
    // acc: partial product high half / partial remainder
    // qr : multiplier being consumed / quotient being built
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] qr;
    logic [WIDTH-1:0] opd;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;

    logic             sgn_op;
    logic             b_zero_div;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    assign sgn_op     = ~op[0];
    assign b_zero_div = op[1] && (b == '0);

    // MIN_INT maps to 2^(W-1), which still fits W unsigned bits.
    assign a_mag = WIDTH'(cond_neg(MAX_W'(a), sgn_op & a[WIDTH-1]));
    assign b_mag = WIDTH'(cond_neg(MAX_W'(b), sgn_op & b[WIDTH-1]));

    assign mul_sum  = {1'b0, acc} + (qr[0] ? {1'b0, opd} : '0);
    assign div_sh   = {acc, qr[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opd};
    assign div_ge   = ~div_diff[WIDTH];

    assign prod_fix = (2*WIDTH)'(cond_neg(MAX_W'({acc, qr}), neg_q));
    assign quo_fix  = WIDTH'(cond_neg(MAX_W'(qr), neg_q));
    assign rem_fix  = WIDTH'(cond_neg(MAX_W'(acc), neg_r));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        if (flush) begin
            nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        nxt = b_zero_div ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        nxt = S_FIX;
                    end
                end
                S_FIX:   nxt = S_DONE;
                S_DONE:  nxt = S_IDLE;
                default: nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            acc         <= '0;
            qr          <= '0;
            opd         <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else if (!flush) begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt         <= CNT_W'(WIDTH);
                        acc         <= '0;
                        qr          <= a_mag;
                        opd         <= b_mag;
                        is_div      <= op[1];
                        neg_q       <= sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r       <= sgn_op & a[WIDTH-1];
                        div_by_zero <= b_zero_div;
                    end
                end
                S_RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (is_div) begin
                        acc <= div_ge ? div_diff[WIDTH-1:0]
                                      : div_sh[WIDTH-1:0];
                        qr  <= {qr[WIDTH-2:0], div_ge};
                    end else begin
                        acc <= mul_sum[WIDTH:1];
                        qr  <= {mul_sum[0], qr[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
// Cycle 1 is the cycle right after the start edge.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op    = 2'b00;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         flush = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;

    int n_run  = 0;
    int n_fail = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issues one request, leaves at #1 after the edge where done is seen.
    task automatic run_op(input logic [1:0] o,
                          input logic [W-1:0] x,
                          input logic [W-1:0] y,
                          output int cyc);
        int guard = 0;
        tick();
        while (busy && guard < 100) begin
            tick();
            guard++;
        end
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
        if (!done) check("timeout", 0, 1);
    endtask

    int  cyc;
    logic seen_done;

    initial begin
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_dbz", div_by_zero, 0);
        @(negedge clock);
        reset = 1'b1;

        // MULT -3 * 5
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, cyc);
        check("mult_lat", cyc, 34);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFF1);
        tick();
        check("done_pulse", done, 0);

        // MULT -3 * -5
        run_op(2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFB, cyc);
        check("multnn_hi", hi, 0);
        check("multnn_lo", lo, 15);

        // MULTU max * max
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        // DIV -7 / 2
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, cyc);
        check("div_lat", cyc, 34);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // DIV 7 / -2
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, cyc);
        check("divpn_lo", lo, 32'hFFFF_FFFD);
        check("divpn_hi", hi, 1);

        // DIV MIN_INT / -1 wraps
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        check("divov_lo", lo, 32'h8000_0000);
        check("divov_hi", hi, 0);

        // DIVU 0x451 / 0x20 -> hi=0x11, lo=0x22
        run_op(2'b11, 32'h451, 32'h20, cyc);
        check("divu_hi", hi, 32'h11);
        check("divu_lo", lo, 32'h22);

        // start during the done cycle is ignored
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd1;
        b     = 32'd1;
        tick();
        start = 1'b0;
        check("start_in_done", busy, 0);

        // DIVU by zero
        run_op(2'b11, 32'd7, 32'd0, cyc);
        check("dbz_lat", cyc, 1);
        check("dbz_flag", div_by_zero, 1);
        check("dbz_hi", hi, 32'h11);
        check("dbz_lo", lo, 32'h22);
        tick();
        check("dbz_held", div_by_zero, 1);

        // MULTU 3*4 with stray starts, then flush at cycle 10
        op    = 2'b01;
        a     = 32'd3;
        b     = 32'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("dbz_clear", div_by_zero, 0);
        for (int c = 1; c < 10; c++) begin
            if (c == 3 || c == 4) begin
                start = 1'b1;
                a     = 32'd99;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check("busy_run", busy, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", busy, 0);
        seen_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done) seen_done = 1'b1;
            tick();
        end
        check("flush_nodone", seen_done, 0);
        check("flush_hi", hi, 32'h11);
        check("flush_lo", lo, 32'h22);

        run_op(2'b01, 32'd3, 32'd4, cyc);
        check("restart_lat", cyc, 34);
        check("restart_lo", lo, 12);
        check("restart_hi", hi, 0);

        // reset mid-DIV
        op    = 2'b10;
        a     = 32'd1000;
        b     = 32'd3;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        reset = 1'b0;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_hi", hi, 0);
        check("mrst_lo", lo, 0);
        check("mrst_dbz", div_by_zero, 0);
        @(negedge clock);
        reset = 1'b1;

        run_op(2'b11, 32'd100, 32'd7, cyc);
        check("divu2_lo", lo, 14);
        check("divu2_hi", hi, 2);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
